// File: rtl/exec_pkg.sv
// Shared encodings for the EX stage: ALU control, alu_op values, R-type functs
// and the mul/div unit's operation and state types.
package exec_pkg;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_NOR,
    ALU_SLT,
    ALU_SLTU,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_MFHI,
    ALU_MFLO,
    ALU_NOP
  } alu_ctrl_e;

  localparam logic [1:0] AOP_ADD   = 2'b00;
  localparam logic [1:0] AOP_SUB   = 2'b01;
  localparam logic [1:0] AOP_RTYPE = 2'b10;
  localparam logic [1:0] AOP_ORI   = 2'b11;

  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;

  // Mul/div op is funct[1:0] of the mult/multu/div/divu group.
  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_RUN,
    MD_FIX
  } md_state_e;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative multiply (shift-add) / divide (restoring) unit with HI/LO registers.
// Signed ops run on magnitudes; the sign is applied in the FIX cycle.
module muldiv_iter
  import exec_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int unsigned CW = $clog2(XLEN + 1);

  md_state_e         state, state_nx;
  logic [CW-1:0]     cnt;
  logic [2*XLEN:0]   acc, acc_step;
  logic [XLEN-1:0]   mb, a_raw;
  logic              is_div, neg_q, neg_r, div0;

  logic              sgn, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  always_comb begin
    sgn   = !op[0];
    a_neg = sgn && a[XLEN-1];
    b_neg = sgn && b[XLEN-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
  end

  // acc holds {carry/remainder, low half}; mul shifts right, div shifts left.
  always_comb begin
    mul_sum   = acc[2*XLEN:XLEN] + (acc[0] ? {1'b0, mb} : '0);
    div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff  = div_shift - {1'b0, mb};
    if (is_div) begin
      if (div_diff[XLEN]) acc_step = {div_shift, acc[XLEN-2:0], 1'b0};
      else                acc_step = {div_diff, acc[XLEN-2:0], 1'b1};
    end else begin
      acc_step = {1'b0, mul_sum, acc[XLEN-1:1]};
    end
  end

  always_comb begin
    prod_fix = neg_q ? -acc[2*XLEN-1:0] : acc[2*XLEN-1:0];
    quo_fix  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_fix  = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_nx = state;
    busy     = (state != MD_IDLE);
    case (state)
      MD_IDLE: if (start) state_nx = MD_RUN;
      MD_RUN:  if (cnt == CW'(XLEN - 1)) state_nx = MD_FIX;
      MD_FIX:  state_nx = MD_IDLE;
      default: state_nx = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= MD_IDLE;
      cnt    <= '0;
      acc    <= '0;
      mb     <= '0;
      a_raw  <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      state <= state_nx;
      case (state)
        MD_IDLE: begin
          if (start) begin
            acc    <= {{(XLEN+1){1'b0}}, a_mag};
            mb     <= b_mag;
            a_raw  <= a;
            is_div <= op[1];
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            div0   <= (b == '0);
            cnt    <= '0;
          end
        end
        MD_RUN: begin
          acc <= acc_step;
          cnt <= cnt + 1'b1;
        end
        MD_FIX: begin
          if (is_div && div0) begin
            hi <= a_raw;
            lo <= '1;
          end else if (is_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/execute_stage_md.sv
// Registered MIPS EX stage: decode, ALU, branch target/compare, destination select,
// plus an optional iterative mul/div unit that stalls the upstream handshake.
module execute_stage_md
  import exec_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RADDR_W   = 5,
  parameter int unsigned MULDIV_EN = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    rs_data,
  input  logic [XLEN-1:0]    rt_data,
  input  logic [XLEN-1:0]    imm,
  input  logic [XLEN-1:0]    pc_plus4,
  input  logic [1:0]         alu_op,
  input  logic               alu_src,
  input  logic               reg_dst,
  input  logic               reg_write_in,
  input  logic [RADDR_W-1:0] rt_addr,
  input  logic [RADDR_W-1:0] rd_addr,
  output logic               out_valid,
  output logic [XLEN-1:0]    alu_result,
  output logic [XLEN-1:0]    branch_target,
  output logic               zero,
  output logic [RADDR_W-1:0] write_register,
  output logic               reg_write,
  output logic               busy
);

  localparam bit HAS_MD = (MULDIV_EN != 0);

  logic [15:0]     imm16;
  logic [5:0]      funct;
  logic [4:0]      shamt;
  logic [XLEN-1:0] imm_zext, op_b, alu_res, hi, lo;
  alu_ctrl_e       ctrl;
  logic            md_issue, md_busy, xfer;

  // Low 16 immediate bits, sign-extended when XLEN is narrower than 16.
  assign imm16    = 16'($signed(imm));
  assign funct    = imm16[5:0];
  assign shamt    = imm16[10:6];
  assign imm_zext = XLEN'(imm16);

  assign busy     = md_busy;
  assign in_ready = !md_busy;
  assign xfer     = in_valid && in_ready;

  generate
    if (HAS_MD) begin : g_md
      muldiv_iter #(.XLEN(XLEN)) u_muldiv (
        .clk   (clk),
        .rst_n (reset),
        .start (xfer && md_issue),
        .op    (funct[1:0]),
        .a     (rs_data),
        .b     (rt_data),
        .busy  (md_busy),
        .hi    (hi),
        .lo    (lo)
      );
    end else begin : g_no_md
      assign md_busy = 1'b0;
      assign hi      = '0;
      assign lo      = '0;
    end
  endgenerate

  always_comb begin
    ctrl     = ALU_NOP;
    md_issue = 1'b0;
    case (alu_op)
      AOP_ADD: ctrl = ALU_ADD;
      AOP_SUB: ctrl = ALU_SUB;
      AOP_ORI: ctrl = ALU_OR;
      default: begin
        case (funct)
          FN_ADD:  ctrl = ALU_ADD;
          FN_SUB:  ctrl = ALU_SUB;
          FN_AND:  ctrl = ALU_AND;
          FN_OR:   ctrl = ALU_OR;
          FN_XOR:  ctrl = ALU_XOR;
          FN_NOR:  ctrl = ALU_NOR;
          FN_SLT:  ctrl = ALU_SLT;
          FN_SLTU: ctrl = ALU_SLTU;
          FN_SLL:  ctrl = ALU_SLL;
          FN_SRL:  ctrl = ALU_SRL;
          FN_SRA:  ctrl = ALU_SRA;
          FN_MFHI: if (HAS_MD) ctrl = ALU_MFHI;
          FN_MFLO: if (HAS_MD) ctrl = ALU_MFLO;
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: md_issue = HAS_MD;
          default: ctrl = ALU_NOP;
        endcase
      end
    endcase
  end

  always_comb begin
    if (!alu_src)              op_b = rt_data;
    else if (alu_op == AOP_ORI) op_b = imm_zext;
    else                       op_b = imm;
  end

  always_comb begin
    alu_res = '0;
    case (ctrl)
      ALU_ADD:  alu_res = rs_data + op_b;
      ALU_SUB:  alu_res = rs_data - op_b;
      ALU_AND:  alu_res = rs_data & op_b;
      ALU_OR:   alu_res = rs_data | op_b;
      ALU_XOR:  alu_res = rs_data ^ op_b;
      ALU_NOR:  alu_res = ~(rs_data | op_b);
      ALU_SLT:  alu_res = XLEN'($signed(rs_data) < $signed(op_b));
      ALU_SLTU: alu_res = XLEN'(rs_data < op_b);
      ALU_SLL:  alu_res = rt_data << shamt;
      ALU_SRL:  alu_res = rt_data >> shamt;
      ALU_SRA:  alu_res = $unsigned($signed(rt_data) >>> shamt);
      ALU_MFHI: alu_res = hi;
      ALU_MFLO: alu_res = lo;
      default:  alu_res = '0;
    endcase
  end

  // Non-transfer cycles only drop out_valid; the payload holds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid      <= 1'b0;
      alu_result     <= '0;
      branch_target  <= '0;
      zero           <= 1'b0;
      write_register <= '0;
      reg_write      <= 1'b0;
    end else begin
      out_valid <= xfer;
      if (xfer) begin
        alu_result     <= alu_res;
        branch_target  <= pc_plus4 + (imm << 2);
        zero           <= (alu_op == AOP_SUB) && (rs_data == rt_data);
        write_register <= reg_dst ? rd_addr : rt_addr;
        reg_write      <= reg_write_in && (ctrl != ALU_NOP);
      end
    end
  end

endmodule
